mul_hilo_ctrl: RTL and testbench
================================

// Module: mul_hilo_ctrl
// PURPOSE
//  Multi-cycle sequencer wrapped around the combinational signed 32x32 Booth
//  multiplier. Latches operands on start and holds them stable at the multiplier
//  inputs for SETTLE_CYCLES clocks (multicycle path). Then captures the 64-bit
//  product into the HI/LO register pair read by the datapath (mfhi/mflo).
//  Also services direct HI/LO writes (mthi/mtlo).
// PARAMETERS
//  SETTLE_CYCLES  4   clocks operands are held before product capture; legal >=1
//  CNT_W          3   counter width; must satisfy 2**CNT_W > SETTLE_CYCLES
// PORTS
//  clk      in   1   clock; all state updates on rising edge
//  clr      in   1   synchronous active-high reset
//  start    in   1   request multiply of op_a*op_b; sampled on rising edge
//  op_a     in   32  multiplicand (signed, two's complement)
//  op_b     in   32  multiplier (signed, two's complement)
//  mul_a    out  32  registered operand A to multiplier input A
//  mul_b    out  32  registered operand B to multiplier input B
//  mul_c    in   64  product returned by multiplier (signed)
//  hi_we    in   1   direct write of hi_wd into HI (mthi)
//  lo_we    in   1   direct write of lo_wd into LO (mtlo)
//  hi_wd    in   32  HI write data
//  lo_wd    in   32  LO write data
//  hi       out  32  HI register: product bits [63:32]
//  lo       out  32  LO register: product bits [31:0]
//  busy     out  1   high while in WAIT; start ignored
//  done     out  1   one-cycle pulse; HI/LO hold the new product this cycle
// BEHAVIOUR
//  Reset (clr=1 at edge): state=IDLE, cnt=0, mul_a=mul_b=0, hi=lo=0, busy=0,
//   done=0. Reset overrides everything, including mid-multiply (result discarded).
//  States:
//   IDLE: start=1 -> latch mul_a<=op_a, mul_b<=op_b, cnt<=SETTLE_CYCLES-1,
//    go WAIT.
//   WAIT: busy=1. cnt!=0 -> cnt<=cnt-1. cnt==0 -> hi<=mul_c[63:32],
//    lo<=mul_c[31:0], go DONE.
//   DONE: done=1, busy=0. start=1 -> behave as IDLE accept (back-to-back);
//    else go IDLE.
//  Latency: start accepted at edge E0 -> HI/LO written at edge E0+SETTLE_CYCLES;
//   done high in the cycle after that edge. Throughput: one op per
//   SETTLE_CYCLES+1 clocks.
//  mul_a/mul_b change only on an accepted start. They never change in WAIT.
//  start while busy=1: ignored, not queued.
//  Direct writes: hi_we/lo_we are independent and take effect at the edge in
//   any state. Same edge as product capture -> capture wins for both HI and LO.
//   Direct write during WAIT is overwritten by the later capture.
//  No width extension beyond 64 bits. The signed product of any 32-bit
//   operands fits, including 0x80000000*0x80000000.
// TESTING
//  clr; start op_a=7 op_b=-3 (0xFFFFFFFD) -> done at E0+5 cycle;
//   hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//  op_a=op_b=0x80000000 -> hi=0x40000000, lo=0x00000000; busy high exactly
//   SETTLE_CYCLES clocks.
//  start held high continuously with fresh operands each accept -> results
//   every SETTLE_CYCLES+1 clocks; starts during busy have no effect.
//  hi_we=1 hi_wd=0x12345678 in IDLE -> hi=0x12345678, lo unchanged. Same write
//   on the capture edge -> hi=product[63:32].
//  clr asserted during WAIT -> next cycle hi=lo=0, busy=0, no done pulse;
//   a new start afterwards completes normally.
//  Change op_a/op_b while busy -> mul_a/mul_b stable; product reflects the
//   latched operands.

Source files
------------

// File: rtl/mul_hilo_ctrl_if.sv
// Operand/product and HI/LO access bundle between the datapath and the multiply sequencer.
// The slave modport is the sequencer's view; the master modport is the datapath's view.
interface mul_hilo_ctrl_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [63:0] mul_c;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_wd;
    logic [31:0] lo_wd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport slave (
        input  start, op_a, op_b, mul_c, hi_we, lo_we, hi_wd, lo_wd,
        output mul_a, mul_b, hi, lo, busy, done
    );

    modport master (
        output start, op_a, op_b, mul_c, hi_we, lo_we, hi_wd, lo_wd,
        input  mul_a, mul_b, hi, lo, busy, done
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Multicycle sequencer around a combinational 32x32 signed multiplier: holds the
// operands for SETTLE_CYCLES clocks, then captures the 64-bit product into HI/LO.
module mul_hilo_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  clr,
    mul_hilo_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               accept;
    logic               capture;
    logic [31:0]        mul_a_r, mul_b_r, hi_r, lo_r;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                // DONE accepts a new start directly so back-to-back ops lose no clock
                state_nxt = S_IDLE;
                if (bus.start) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mul_a_r <= '0;
            mul_b_r <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                mul_a_r <= bus.op_a;
                mul_b_r <= bus.op_b;
            end
            // Product capture takes priority over an mthi/mtlo on the same edge
            if (capture)        hi_r <= bus.mul_c[63:32];
            else if (bus.hi_we) hi_r <= bus.hi_wd;
            if (capture)        lo_r <= bus.mul_c[31:0];
            else if (bus.lo_we) lo_r <= bus.lo_wd;
        end
    end

    assign bus.mul_a = mul_a_r;
    assign bus.mul_b = mul_b_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
    assign bus.busy  = (state == S_WAIT);
    assign bus.done  = (state == S_DONE);
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl with a behavioural signed 32x32 multiplier on mul_c.
module tb_mul_hilo_ctrl;
    logic clk = 1'b0;
    logic clr;
    int   tests = 0;
    int   fails = 0;

    mul_hilo_ctrl_if bus();

    mul_hilo_ctrl #(.SETTLE_CYCLES(4), .CNT_W(3)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational multiplier standing in for the Booth array
    logic signed [63:0] ext_a, ext_b;
    assign ext_a     = {{32{bus.mul_a[31]}}, bus.mul_a};
    assign ext_b     = {{32{bus.mul_b[31]}}, bus.mul_b};
    assign bus.mul_c = ext_a * ext_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_busy(input string tag, input int expect_cycles);
        int n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(expect_cycles));
    endtask

    initial begin
        clr       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = 32'h0;
        bus.op_b  = 32'h0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.hi_wd = 32'h0;
        bus.lo_wd = 32'h0;
        tick();
        tick();
        clr = 1'b0;
        chk("rst_hi",   64'(bus.hi),    64'h0);
        chk("rst_lo",   64'(bus.lo),    64'h0);
        chk("rst_busy", 64'(bus.busy),  64'h0);
        chk("rst_done", 64'(bus.done),  64'h0);
        chk("rst_mula", 64'(bus.mul_a), 64'h0);

        // 7 * -3, done must appear exactly after the 4th WAIT edge
        bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFD; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("m1_busy0", 64'(bus.busy),  64'h1);
        chk("m1_mula",  64'(bus.mul_a), 64'h7);
        chk("m1_mulb",  64'(bus.mul_b), 64'hFFFF_FFFD);
        tick(); tick(); tick();
        chk("m1_busy3", 64'(bus.busy),  64'h1);
        chk("m1_ndone", 64'(bus.done),  64'h0);
        tick();
        chk("m1_done",  64'(bus.done),  64'h1);
        chk("m1_nbusy", 64'(bus.busy),  64'h0);
        chk("m1_hi",    64'(bus.hi),    64'hFFFF_FFFF);
        chk("m1_lo",    64'(bus.lo),    64'hFFFF_FFEB);
        tick();
        chk("m1_pulse", 64'(bus.done),  64'h0);

        // Most negative squared; operands wiggled and start raised while busy
        bus.op_a = 32'h8000_0000; bus.op_b = 32'h8000_0000; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op_a  = 32'h1111_1111; bus.op_b = 32'h2222_2222;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("m2_mula_hold", 64'(bus.mul_a), 64'h8000_0000);
        chk("m2_mulb_hold", 64'(bus.mul_b), 64'h8000_0000);
        tick(); tick();
        chk("m2_done", 64'(bus.done), 64'h1);
        chk("m2_hi",   64'(bus.hi),   64'h4000_0000);
        chk("m2_lo",   64'(bus.lo),   64'h0);
        tick();

        // Exact busy length
        bus.op_a = 32'd10; bus.op_b = 32'd10; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_busy("m3_busy_len", 4);
        chk("m3_lo", 64'(bus.lo), 64'd100);
        tick();

        // start held high: results every 5 clocks, busy-time operands ignored
        bus.op_a = 32'd2; bus.op_b = 32'd3; bus.start = 1'b1;
        tick();
        bus.op_a = 32'd5; bus.op_b = 32'd6;
        tick(); tick(); tick();
        chk("b2b_mula", 64'(bus.mul_a), 64'd2);
        tick();
        chk("b2b1_done", 64'(bus.done), 64'h1);
        chk("b2b1_hi",   64'(bus.hi),   64'h0);
        chk("b2b1_lo",   64'(bus.lo),   64'd6);
        tick();
        chk("b2b2_busy", 64'(bus.busy),  64'h1);
        chk("b2b2_mula", 64'(bus.mul_a), 64'd5);
        bus.op_a = 32'hFFFF_FFFE; bus.op_b = 32'd4;
        tick(); tick(); tick(); tick();
        chk("b2b2_done", 64'(bus.done), 64'h1);
        chk("b2b2_lo",   64'(bus.lo),   64'd30);
        tick();
        bus.start = 1'b0;
        chk("b2b3_busy", 64'(bus.busy), 64'h1);
        tick(); tick(); tick(); tick();
        chk("b2b3_done", 64'(bus.done), 64'h1);
        chk("b2b3_hi",   64'(bus.hi),   64'hFFFF_FFFF);
        chk("b2b3_lo",   64'(bus.lo),   64'hFFFF_FFF8);
        tick();

        // Direct writes in IDLE
        bus.hi_we = 1'b1; bus.hi_wd = 32'h1234_5678;
        tick();
        bus.hi_we = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'h1234_5678);
        chk("mthi_lo", 64'(bus.lo), 64'hFFFF_FFF8);
        bus.lo_we = 1'b1; bus.lo_wd = 32'hCAFE_BABE;
        tick();
        bus.lo_we = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'hCAFE_BABE);
        chk("mtlo_hi", 64'(bus.hi), 64'h1234_5678);

        // Write during WAIT lands, then capture overrides a same-edge write
        bus.op_a = 32'd3; bus.op_b = 32'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.hi_we = 1'b1; bus.hi_wd = 32'hAAAA_5555;
        tick();
        bus.hi_we = 1'b0;
        chk("wait_mthi", 64'(bus.hi), 64'hAAAA_5555);
        tick(); tick();
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        bus.hi_wd = 32'hDEAD_BEEF; bus.lo_wd = 32'hDEAD_BEEF;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("cap_win_done", 64'(bus.done), 64'h1);
        chk("cap_win_hi",   64'(bus.hi),   64'h0);
        chk("cap_win_lo",   64'(bus.lo),   64'd12);
        tick();

        // clr mid-multiply discards the operation
        bus.op_a = 32'd9; bus.op_b = 32'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_hi",   64'(bus.hi),    64'h0);
        chk("clr_lo",   64'(bus.lo),    64'h0);
        chk("clr_busy", 64'(bus.busy),  64'h0);
        chk("clr_mula", 64'(bus.mul_a), 64'h0);
        tick(); tick(); tick();
        chk("clr_nodone", 64'(bus.done), 64'h0);
        chk("clr_lo2",    64'(bus.lo),   64'h0);

        bus.op_a = 32'hFFFF_FFFB; bus.op_b = 32'hFFFF_FFFB; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_busy("post_clr_busy_len", 4);
        chk("post_clr_done", 64'(bus.done), 64'h1);
        chk("post_clr_hi",   64'(bus.hi),   64'h0);
        chk("post_clr_lo",   64'(bus.lo),   64'd25);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
